// File: rtl/rf_wr_arbiter_if.sv
// Write-port arbitration bundle between requesters/decode and rf_wr_arbiter.
// The dbg_* signals exist only when RF_DBG_WR_EN is defined.
interface rf_wr_arbiter_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_AWIDTH = 5
);
  logic                        wb_req_valid_i;
  logic                        wb_req_ready_o;
  logic [RF_AWIDTH-1:0]        wb_rd_addr_i;
  logic [XLEN-1:0]             wb_rd_data_i;

  logic                        lsu_req_valid_i;
  logic                        lsu_req_ready_o;
  logic [RF_AWIDTH-1:0]        lsu_rd_addr_i;
  logic [XLEN-1:0]             lsu_rd_data_i;
  logic                        lsu_issue_valid_i;
  logic [RF_AWIDTH-1:0]        lsu_issue_addr_i;

  logic [RF_AWIDTH-1:0]        id_rs1_addr_i;
  logic [RF_AWIDTH-1:0]        id_rs2_addr_i;
  logic [RF_AWIDTH-1:0]        id_rd_addr_i;
  logic                        id_stall_o;
  logic [(2**RF_AWIDTH)-1:0]   rf_busy_o;

  logic                        rf_wr_req_o;
  logic [RF_AWIDTH-1:0]        rf_rd_addr_o;
  logic [XLEN-1:0]             rf_rd_data_o;

`ifdef RF_DBG_WR_EN
  logic                        dbg_req_valid_i;
  logic                        dbg_req_ready_o;
  logic [RF_AWIDTH-1:0]        dbg_rd_addr_i;
  logic [XLEN-1:0]             dbg_rd_data_i;
`endif

  modport master (
    output wb_req_valid_i, wb_rd_addr_i, wb_rd_data_i,
    output lsu_req_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
    output lsu_issue_valid_i, lsu_issue_addr_i,
    output id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
`ifdef RF_DBG_WR_EN
    output dbg_req_valid_i, dbg_rd_addr_i, dbg_rd_data_i,
    input  dbg_req_ready_o,
`endif
    input  wb_req_ready_o, lsu_req_ready_o,
    input  id_stall_o, rf_busy_o,
    input  rf_wr_req_o, rf_rd_addr_o, rf_rd_data_o
  );

  modport slave (
    input  wb_req_valid_i, wb_rd_addr_i, wb_rd_data_i,
    input  lsu_req_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
    input  lsu_issue_valid_i, lsu_issue_addr_i,
    input  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
`ifdef RF_DBG_WR_EN
    input  dbg_req_valid_i, dbg_rd_addr_i, dbg_rd_data_i,
    output dbg_req_ready_o,
`endif
    output wb_req_ready_o, lsu_req_ready_o,
    output id_stall_o, rf_busy_o,
    output rf_wr_req_o, rf_rd_addr_o, rf_rd_data_o
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter (WB / LSU / optional DBG) with LSU load scoreboard.
// Define RF_DBG_WR_EN to add the debug write requester with absolute priority.
module rf_wr_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RF_AWIDTH    = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  rf_wr_arbiter_if.slave   bus
);
  localparam int unsigned NumRegs   = 2**RF_AWIDTH;
  localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

  logic [3:0]           starve_q, starve_d;
  logic [NumRegs-1:0]   busy_q, busy_d;
  logic                 wr_req_q;
  logic [RF_AWIDTH-1:0] addr_q;
  logic [XLEN-1:0]      data_q;

  logic                 promote;
  logic                 dbg_gnt, lsu_gnt, wb_gnt, any_gnt;
  logic [RF_AWIDTH-1:0] gnt_addr;
  logic [XLEN-1:0]      gnt_data;

  assign promote = (starve_q == StarveMax);

  // Readies are forced low while rst is high.
  always_comb begin
    dbg_gnt = 1'b0;
    lsu_gnt = 1'b0;
    wb_gnt  = 1'b0;
    if (!rst) begin
`ifdef RF_DBG_WR_EN
      dbg_gnt = bus.dbg_req_valid_i;
`endif
      lsu_gnt = bus.lsu_req_valid_i && !dbg_gnt && (promote || !bus.wb_req_valid_i);
      wb_gnt  = bus.wb_req_valid_i && !dbg_gnt && !lsu_gnt;
    end
  end

  assign any_gnt = dbg_gnt | lsu_gnt | wb_gnt;

  always_comb begin
    gnt_addr = bus.wb_rd_addr_i;
    gnt_data = bus.wb_rd_data_i;
    if (lsu_gnt) begin
      gnt_addr = bus.lsu_rd_addr_i;
      gnt_data = bus.lsu_rd_data_i;
    end
`ifdef RF_DBG_WR_EN
    if (dbg_gnt) begin
      gnt_addr = bus.dbg_rd_addr_i;
      gnt_data = bus.dbg_rd_data_i;
    end
`endif
  end

  // Any lost LSU cycle counts, including losses to DBG.
  always_comb begin
    if (!bus.lsu_req_valid_i || lsu_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q < StarveMax) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Issue is applied after the return clear so a same-cycle reissue keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (lsu_gnt) begin
      busy_d[bus.lsu_rd_addr_i] = 1'b0;
    end
    if (bus.lsu_issue_valid_i) begin
      busy_d[bus.lsu_issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      busy_q   <= '0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      wr_req_q <= any_gnt && (gnt_addr != '0);
      if (any_gnt) begin
        addr_q <= gnt_addr;
        data_q <= gnt_data;
      end
    end
  end

  assign bus.wb_req_ready_o  = wb_gnt;
  assign bus.lsu_req_ready_o = lsu_gnt;
`ifdef RF_DBG_WR_EN
  assign bus.dbg_req_ready_o = dbg_gnt;
`endif

  assign bus.id_stall_o = busy_q[bus.id_rs1_addr_i] | busy_q[bus.id_rs2_addr_i] |
                          busy_q[bus.id_rd_addr_i];
  assign bus.rf_busy_o    = busy_q;
  assign bus.rf_wr_req_o  = wr_req_q;
  assign bus.rf_rd_addr_o = addr_q;
  assign bus.rf_rd_data_o = data_q;
endmodule
